// File: rtl/i2c_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter_if
//
// Bundles every signal of the requester-side and master-side buses of the
// I2C bus arbiter so a single port carries them.
//
// Requester side (NUM_REQ requesters, packed per requester):
//   req        level request per requester
//   req_addr   7-bit slave address, requester i at [7i+6:7i]
//   req_data   32-bit write payload, requester i at [32i+31:32i]
//   req_rw     1 = read, 0 = write
//   gnt        one-hot owner, high from grant through completion
//   done       one-cycle completion pulse to the owner
//   err        one-cycle pulse with done when the transaction timed out
//   rdata      byte captured from the master at completion
//
// Master side (drives one i2c_master_controller):
//   m_enable, m_addr, m_data, m_rw   outputs towards the master
//   m_ready, m_data_out              inputs from the master
//
// Debug:
//   dbg_state  current arbiter FSM state
//
// Modports:
//   master  the arbiter itself
//   slave   the environment (requesters plus the I2C master)
// ---------------------------------------------------------------------------
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [7*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_rw;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic                  err;
    logic [7:0]            rdata;

    logic                  m_enable;
    logic [6:0]            m_addr;
    logic [31:0]           m_data;
    logic                  m_rw;
    logic                  m_ready;
    logic [7:0]            m_data_out;

    logic [1:0]            dbg_state;

    modport master (
        input  req, req_addr, req_data, req_rw, m_ready, m_data_out,
        output gnt, done, err, rdata, m_enable, m_addr, m_data, m_rw,
               dbg_state
    );

    modport slave (
        output req, req_addr, req_data, req_rw, m_ready, m_data_out,
        input  gnt, done, err, rdata, m_enable, m_addr, m_data, m_rw,
               dbg_state
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Round-robin arbiter and transaction sequencer sharing one I2C master among
// NUM_REQ requesters. The winner's command is latched onto the master inputs,
// the master's ready is tracked through one full transaction, and the owner
// receives a one-cycle done pulse (with err when the watchdog fired).
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   TIMEOUT   max clk cycles spent in ISSUE or in BUSY before abort
//
// Ports:
//   clk     system clock (same clock as the I2C master)
//   rst_n   synchronous active-low reset
//   bus     i2c_bus_arbiter_if.master (requester and master-side signals)
//
// Handshake: a requester raises req with a stable payload and holds both
// until its done pulse; the payload is sampled only on the grant edge.
// Towards the master, enable is held from grant until ready falls (the
// master has accepted), then dropped so the master finishes with a STOP;
// ready rising again marks completion. Every output is a register.
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_bus_arbiter_if.master bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [WDOG_W-1:0]  r_wdog;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err;
    logic [7:0]         r_rdata;
    logic               r_m_enable;
    logic [6:0]         r_m_addr;
    logic [31:0]        r_m_data;
    logic               r_m_rw;

    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_pos;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [6:0]         w_sel_addr;
    logic [31:0]        w_sel_data;
    logic               w_sel_rw;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [WDOG_W-1:0]  w_wdog_inc;
    logic               w_timeout;

    // Round-robin scan: first requester with req set, starting at r_ptr and
    // wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req[w_pos]) begin
                w_found = 1'b1;
                w_sel   = w_pos;
            end
        end
    end

    // Payload of the selected requester, picked with constant slices.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_rw   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == PTR_W'(i)) begin
                w_sel_addr = bus.req_addr[7*i +: 7];
                w_sel_data = bus.req_data[32*i +: 32];
                w_sel_rw   = bus.req_rw[i];
            end
        end
    end

    assign w_sel_onehot = NUM_REQ'(1) << w_sel;

    // Pointer moves just past the owner so a requester that keeps req high
    // waits behind every other pending requester.
    assign w_ptr_next = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + PTR_W'(1);

    // The watchdog fires on the edge where its count would reach TIMEOUT,
    // so done/err appear exactly TIMEOUT cycles after the phase started.
    assign w_wdog_inc = r_wdog + WDOG_W'(1);
    assign w_timeout  = (w_wdog_inc == WDOG_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_wdog     <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_rdata    <= 8'h00;
            r_m_enable <= 1'b0;
            r_m_addr   <= '0;
            r_m_data   <= '0;
            r_m_rw     <= 1'b0;
        end else begin
            // done/err are single-cycle: set on entry to DONE, cleared here.
            r_done <= '0;
            r_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // No grant while the master is still busy.
                    if (bus.m_ready && w_found) begin
                        r_idx      <= w_sel;
                        r_gnt      <= w_sel_onehot;
                        r_m_addr   <= w_sel_addr;
                        r_m_data   <= w_sel_data;
                        r_m_rw     <= w_sel_rw;
                        r_m_enable <= 1'b1;
                        r_wdog     <= '0;
                        r_state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!bus.m_ready) begin
                        // Master left its idle state: command accepted.
                        r_m_enable <= 1'b0;
                        r_wdog     <= '0;
                        r_state    <= ST_BUSY;
                    end else if (w_timeout) begin
                        r_m_enable <= 1'b0;
                        r_done     <= r_gnt;
                        r_err      <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end

                ST_BUSY: begin
                    if (bus.m_ready) begin
                        r_rdata <= bus.m_data_out;
                        r_done  <= r_gnt;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        // Abort keeps the previous rdata.
                        r_m_enable <= 1'b0;
                        r_done     <= r_gnt;
                        r_err      <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end

                ST_DONE: begin
                    r_gnt   <= '0;
                    r_ptr   <= w_ptr_next;
                    r_wdog  <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.m_enable  = r_m_enable;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_data    = r_m_data;
    assign bus.m_rw      = r_m_rw;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//
// Drives rounds of requests into i2c_bus_arbiter against a stub I2C master.
// For each round a reference model works out the service order from the
// round-robin rule and pushes one expected completion per transaction; a
// monitor pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT     = 40;
    localparam int MAXREP      = 3;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_STUCK  = 1;
    localparam int MODE_HANG   = 2;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        rw;
    } pl_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] owner;
        pl_t                pl;
        logic [7:0]         rdata;
        logic               err;
        logic               chk_lat;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    i2c_bus_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- scoreboard state ----------------
    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         stub_mode = MODE_NORMAL;
    pl_t        pl[NUM_REQ][MAXREP];
    int         reps[NUM_REQ];
    int         model_ptr = 0;
    logic [7:0] model_rdata = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte the stub slave returns for a given command.
    function automatic logic [7:0] slave_byte(input pl_t p);
        return p.data[31:24] ^ {1'b0, p.addr};
    endfunction

    function automatic pl_t gen_pl();
        pl_t p;
        p.addr = 7'($urandom);
        p.data = $urandom;
        p.rw   = 1'($urandom);
        return p;
    endfunction

    // ---------------- stub I2C master ----------------
    initial begin
        int s;
        int dly;
        int blen;
        s    = 0;
        dly  = 0;
        blen = 0;
        bus.m_ready    = 1'b1;
        bus.m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            case (s)
                0: if (bus.m_enable === 1'b1 && stub_mode != MODE_STUCK) begin
                    dly  = $urandom_range(0, 3);
                    blen = $urandom_range(3, 8);
                    if (dly == 0) begin
                        bus.m_ready = 1'b0;
                        s = (stub_mode == MODE_HANG) ? 3 : 2;
                    end else begin
                        s = 1;
                    end
                end
                1: begin
                    dly--;
                    if (dly == 0) begin
                        bus.m_ready = 1'b0;
                        s = (stub_mode == MODE_HANG) ? 3 : 2;
                    end
                end
                2: begin
                    bus.m_data_out = 8'($urandom);
                    blen--;
                    if (blen == 0) begin
                        bus.m_data_out = bus.m_data[31:24] ^ {1'b0, bus.m_addr};
                        bus.m_ready    = 1'b1;
                        s = 0;
                    end
                end
                3: begin
                    bus.m_data_out = 8'($urandom);
                    if (bus.done != '0) begin
                        bus.m_ready = 1'b1;
                        s = 0;
                    end
                end
                default: s = 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [NUM_REQ-1:0] prev_gnt;
        int   gcyc;
        exp_t e;
        prev_gnt = '0;
        gcyc     = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_gnt = '0;
                continue;
            end
            if (bus.gnt != '0 && prev_gnt == '0) begin
                gcyc = cyc;
                check("enable_at_grant", bus.m_enable, 1);
            end
            if (bus.gnt != '0) check("gnt_onehot", $onehot(bus.gnt), 1);
            if (bus.err) check("err_with_done", bus.done != '0, 1);
            if (bus.done != '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=%b, expected no completion", bus.done);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", bus.done, e.owner);
                    check("gnt_at_done", bus.gnt, e.owner);
                    check("err", bus.err, e.err);
                    check("rdata", bus.rdata, e.rdata);
                    check("m_addr", bus.m_addr, e.pl.addr);
                    check("m_data", bus.m_data, e.pl.data);
                    check("m_rw", bus.m_rw, e.pl.rw);
                    check("enable_at_done", bus.m_enable, 0);
                    if (e.chk_lat) check("timeout_latency", cyc - gcyc, TIMEOUT);
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_payload(input int i, input pl_t p);
        bus.req_addr[7*i +: 7]   = p.addr;
        bus.req_data[32*i +: 32] = p.data;
        bus.req_rw[i]            = p.rw;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_m_enable"}, bus.m_enable, 0);
        check({tag, "_m_addr"}, bus.m_addr, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
        check({tag, "_m_rw"}, bus.m_rw, 0);
    endtask

    // One round: requester i asks reps[i] times in a row, keeping req high
    // between its own transactions and dropping it after the last done.
    task automatic run_round(input int mode, input bit rand_payload);
        int r[NUM_REQ];
        int served[NUM_REQ];
        int ptr;
        int total;
        int got;
        int budget;
        int first;
        logic [NUM_REQ-1:0] oh;
        exp_t e;

        stub_mode = mode;
        if (rand_payload) begin
            for (int i = 0; i < NUM_REQ; i++)
                for (int k = 0; k < reps[i]; k++) pl[i][k] = gen_pl();
        end

        // Reference: the pending requester nearest at or after the pointer
        // is served next; the pointer then moves just past it.
        ptr   = model_ptr;
        total = 0;
        first = -1;
        for (int i = 0; i < NUM_REQ; i++) r[i] = reps[i];
        while (1) begin
            int pick;
            pick = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pick < 0 && r[(ptr + k) % NUM_REQ] > 0) pick = (ptr + k) % NUM_REQ;
            end
            if (pick < 0) break;
            oh = '0;
            oh[pick] = 1'b1;
            e.owner = oh;
            e.pl    = pl[pick][reps[pick] - r[pick]];
            if (mode == MODE_NORMAL) model_rdata = slave_byte(e.pl);
            e.rdata   = model_rdata;
            e.err     = (mode != MODE_NORMAL);
            e.chk_lat = (mode == MODE_STUCK);
            exp_q.push_back(e);
            r[pick]--;
            ptr = (pick + 1) % NUM_REQ;
            if (first < 0) first = pick;
            total++;
        end
        model_ptr = ptr;

        for (int i = 0; i < NUM_REQ; i++) begin
            served[i] = 0;
            if (reps[i] > 0) begin
                drive_payload(i, pl[i][0]);
                bus.req[i] = 1'b1;
            end
        end

        @(negedge clk);
        oh = '0;
        oh[first] = 1'b1;
        check("grant_latency", bus.gnt, oh);

        got    = 0;
        budget = 0;
        while (got < total && budget < 4000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.done[i]) begin
                    got++;
                    served[i]++;
                    if (served[i] < reps[i]) drive_payload(i, pl[i][served[i]]);
                    else bus.req[i] = 1'b0;
                end else if (bus.gnt[i]) begin
                    // Payload changes after the grant must not reach the master.
                    drive_payload(i, gen_pl());
                end
            end
        end
        if (got < total) begin
            n_checks++;
            n_errors++;
            $display("FAIL round_timeout: got %0d completions, expected %0d", got, total);
            bus.req = '0;
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.rdata, model_rdata);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic reset_mid_busy();
        int   waited;
        bit   saw_done;
        stub_mode = MODE_NORMAL;
        drive_payload(1, gen_pl());
        bus.req[1] = 1'b1;
        waited = 0;
        while (!(bus.gnt != '0 && bus.m_enable == 1'b0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL busy_wait: got no BUSY phase, expected one within 100 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = '0;
        check_reset("rst_busy");
        model_ptr   = 0;
        model_rdata = 8'h00;
        saw_done = 1'b0;
        waited   = 0;
        while (bus.m_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            if (bus.done != '0) saw_done = 1'b1;
            waited++;
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.done != '0) saw_done = 1'b1;
        end
        check("no_done_after_reset", saw_done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   m;
        int   sum;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_rw   = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 1.
        reps = '{0, 1, 0, 0};
        pl[1][0] = {7'h50, 32'hA5A5_1234, 1'b0};
        run_round(MODE_NORMAL, 1'b0);

        // Single read from requester 2; slave byte 0x74 ^ 0x48 = 0x3C.
        reps = '{0, 0, 1, 0};
        pl[2][0] = {7'h48, 32'h7400_00C3, 1'b1};
        run_round(MODE_NORMAL, 1'b0);
        check("read_rdata_3c", bus.rdata, 8'h3C);

        // Reset while BUSY, then pointer must restart at requester 0.
        reset_mid_busy();
        reps = '{1, 0, 0, 1};
        run_round(MODE_NORMAL, 1'b1);

        // Contention 0, 1, 3.
        reps = '{1, 1, 0, 1};
        run_round(MODE_NORMAL, 1'b1);

        // Fairness: requester 0 stays high, requester 2 re-requests.
        reps = '{3, 0, 2, 0};
        run_round(MODE_NORMAL, 1'b1);

        // Master never accepts, then master accepts but never finishes.
        reps = '{0, 0, 0, 1};
        run_round(MODE_STUCK, 1'b1);
        reps = '{0, 1, 0, 0};
        run_round(MODE_HANG, 1'b1);

        for (int n = 0; n < 30; n++) begin
            m   = $urandom_range(0, 9);
            sum = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                reps[i] = $urandom_range(0, MAXREP - 1);
                sum += reps[i];
            end
            if (sum == 0) reps[$urandom_range(0, NUM_REQ - 1)] = 1;
            run_round((m < 8) ? MODE_NORMAL : ((m == 8) ? MODE_STUCK : MODE_HANG), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
